spectrum_peak_det: RTL and testbench

SPECTRUM_PEAK_DET -- requirements
Module: spectrum_peak_det

---
 rtl/spectrum_peak_det_pkg.sv | 18 +
 rtl/spectrum_peak_det_hold.sv | 37 +++
 rtl/spectrum_peak_det.sv | 152 +++++++++++++++
 tb/tb_spectrum_peak_det.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_peak_det_pkg.sv
// Shared definitions for the spectrum peak detector: FSM encoding, default
// geometry of the FFT frame and field widths.
package spectrum_peak_det_pkg;

   localparam int NUM_BINS_DEF    = 512;
   localparam int MIN_BIN_DEF     = 2;
   localparam int DECAY_SHIFT_DEF = 3;
   localparam int ADDR_W          = 10;
   localparam int MAG_W           = 8;
   localparam int OVF_W           = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

endpackage

// File: rtl/spectrum_peak_det_hold.sv
// Peak-hold register: follows a larger frame peak immediately, otherwise
// decays by a fixed fraction per published frame and always reaches zero.
module peak_hold_decay
   import spectrum_peak_det_pkg::*;
#(
   parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             publish,
   input  logic [MAG_W-1:0] run_max,
   output logic [MAG_W-1:0] hold_mag
);

   // A shift that truncates to zero would stall small values, so force a step of 1.
   function automatic logic [MAG_W-1:0] decay_step(input logic [MAG_W-1:0] h);
      logic [MAG_W-1:0] d;
      d = h >> DECAY_SHIFT;
      if ((d == '0) && (h != '0)) d = MAG_W'(1);
      return h - d;
   endfunction

   logic [MAG_W-1:0] hold_nxt;

   always_comb begin
      hold_nxt = hold_mag;
      if (publish) begin
         hold_nxt = (run_max >= hold_mag) ? run_max : decay_step(hold_mag);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hold_mag <= '0;
      else          hold_mag <= hold_nxt;
   end

endmodule

// File: rtl/spectrum_peak_det.sv
// Per-frame strongest-bin search over the FFT magnitude stream, with a
// level result handshake, frame integrity flag and overwrite counter.
module spectrum_peak_det
   import spectrum_peak_det_pkg::*;
#(
   parameter int NUM_BINS    = NUM_BINS_DEF,
   parameter int MIN_BIN     = MIN_BIN_DEF,
   parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_start,
   input  logic              freq_valid,
   input  logic [ADDR_W-1:0] freq_addr,
   input  logic [MAG_W-1:0]  freq_data,
   input  logic              result_ack,
   output logic [MAG_W-1:0]  peak_mag,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [MAG_W-1:0]  hold_mag,
   output logic              result_ready,
   output logic              frame_err,
   output logic [OVF_W-1:0]  overwrite_cnt
);

   localparam int                CNT_W     = $clog2(NUM_BINS + 1);
   localparam logic [ADDR_W-1:0] FIRST_BIN = ADDR_W'(MIN_BIN);
   localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(NUM_BINS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_BINS - MIN_BIN);

   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] c);
      return (c == '1) ? c : c + OVF_W'(1);
   endfunction

   // Stage p0: input capture; control bits reset, sample payload does not.
   logic              frame_start_p0;
   logic              vld_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [MAG_W-1:0]  data_p0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_start_p0 <= 1'b0;
         vld_p0         <= 1'b0;
      end else begin
         frame_start_p0 <= frame_start;
         vld_p0         <= freq_valid;
      end
   end

   always_ff @(posedge clk) begin
      addr_p0 <= freq_addr;
      data_p0 <= freq_data;
   end

   // Stage p1: frame FSM and running maximum.
   state_t            state, state_nxt;
   logic [MAG_W-1:0]  run_max;
   logic [ADDR_W-1:0] run_bin;
   logic [CNT_W-1:0]  sample_cnt;
   logic              abort_flg;
   logic              accept_p0, last_p0;
   logic              start_clr, restart, publish;

   always_comb begin
      accept_p0 = vld_p0 && (addr_p0 >= FIRST_BIN) && (addr_p0 <= LAST_BIN);
      last_p0   = vld_p0 && (addr_p0 == LAST_BIN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_clr = 1'b0;
      restart   = 1'b0;
      publish   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frame_start_p0) begin
               state_nxt = ST_ACQUIRE;
               start_clr = 1'b1;
            end
         end
         ST_ACQUIRE: begin
            // A new strobe wins over any sample arriving in the same cycle.
            if (frame_start_p0) begin
               start_clr = 1'b1;
               restart   = 1'b1;
            end else if (last_p0) begin
               state_nxt = ST_PUBLISH;
            end
         end
         ST_PUBLISH: begin
            publish   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_max    <= '0;
         run_bin    <= '0;
         sample_cnt <= '0;
         abort_flg  <= 1'b0;
      end else if (start_clr) begin
         run_max    <= '0;
         run_bin    <= FIRST_BIN;
         sample_cnt <= '0;
         abort_flg  <= restart;
      end else if ((state == ST_ACQUIRE) && accept_p0) begin
         sample_cnt <= sample_cnt + CNT_W'(1);
         if (data_p0 > run_max) begin
            run_max <= data_p0;
            run_bin <= addr_p0;
         end
      end
   end

   // Stage p2: published result and consumer handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         peak_mag      <= '0;
         peak_bin      <= '0;
         frame_err     <= 1'b0;
         result_ready  <= 1'b0;
         overwrite_cnt <= '0;
      end else if (publish) begin
         peak_mag     <= run_max;
         peak_bin     <= run_bin;
         frame_err    <= (sample_cnt != FULL_CNT) || abort_flg;
         result_ready <= 1'b1;
         if (result_ready && !result_ack) overwrite_cnt <= sat_inc(overwrite_cnt);
      end else if (result_ack) begin
         result_ready <= 1'b0;
      end
   end

   peak_hold_decay #(
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_hold (
      .clk      (clk),
      .reset_n  (reset_n),
      .publish  (publish),
      .run_max  (run_max),
      .hold_mag (hold_mag)
   );

endmodule

// File: tb/tb_spectrum_peak_det.sv
// Bench for spectrum_peak_det: directed and randomized frames checked against
// a frame-level reference model (max search, count, hold decay, handshake).
module tb_spectrum_peak_det;

   localparam int NB = 512;
   localparam int MB = 2;
   localparam int DS = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       frame_start;
   logic       freq_valid;
   logic [9:0] freq_addr;
   logic [7:0] freq_data;
   logic       result_ack;
   logic [7:0] peak_mag;
   logic [9:0] peak_bin;
   logic [7:0] hold_mag;
   logic       result_ready;
   logic       frame_err;
   logic [3:0] overwrite_cnt;

   always #5 clk = ~clk;

   spectrum_peak_det #(
      .NUM_BINS    (NB),
      .MIN_BIN     (MB),
      .DECAY_SHIFT (DS)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .frame_start   (frame_start),
      .freq_valid    (freq_valid),
      .freq_addr     (freq_addr),
      .freq_data     (freq_data),
      .result_ack    (result_ack),
      .peak_mag      (peak_mag),
      .peak_bin      (peak_bin),
      .hold_mag      (hold_mag),
      .result_ready  (result_ready),
      .frame_err     (frame_err),
      .overwrite_cnt (overwrite_cnt)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model of the published state
   int m_hold = 0, m_ready = 0, m_ov = 0, m_peak = 0, m_bin = 0, m_err = 0;

   logic [7:0] fdata [NB];
   bit         gaps     = 1'b0;
   bit         ack_pub  = 1'b0;
   int         skip_bin = -1;
   int         abort_at = -1;

   task automatic set_in(input bit fs, input bit v, input int a, input int d);
      frame_start = fs;
      freq_valid  = v;
      freq_addr   = a[9:0];
      freq_data   = d[7:0];
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, "_ready"}, result_ready, m_ready);
      check_val({tag, "_mag"},   peak_mag,     m_peak);
      check_val({tag, "_bin"},   peak_bin,     m_bin);
      check_val({tag, "_hold"},  hold_mag,     m_hold);
      check_val({tag, "_err"},   frame_err,    m_err);
      check_val({tag, "_ovf"},   overwrite_cnt, m_ov);
   endtask

   task automatic model_reset();
      m_hold = 0; m_ready = 0; m_ov = 0; m_peak = 0; m_bin = 0; m_err = 0;
   endtask

   // Optional idle or out-of-range cycle, then one in-frame bin
   task automatic send_bin(input int b);
      if (gaps && ($urandom_range(0, 7) == 0)) begin
         @(negedge clk);
         if ($urandom_range(0, 1) == 1) set_in(0, 1, $urandom_range(NB, 1023), $urandom_range(0, 255));
         else                           set_in(0, 0, 0, 0);
      end
      @(negedge clk);
      set_in(0, 1, b, fdata[b]);
   endtask

   task automatic run_frame(input string tag);
      int cnt, mx, bn, d;
      bit ab;
      cnt = 0; mx = 0; bn = MB; ab = 1'b0;
      @(negedge clk);
      set_in(1, 0, 0, 0);
      if (abort_at >= 0) begin
         for (int b = 0; b < abort_at; b++) send_bin(b);
         @(negedge clk);
         set_in(1, 0, 0, 0);
         ab = 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
         if (b == skip_bin) continue;
         send_bin(b);
         if (b >= MB) begin
            cnt++;
            if (int'(fdata[b]) > mx) begin
               mx = fdata[b];
               bn = b;
            end
         end
      end
      // Result must not appear before the second edge after the last bin
      @(negedge clk);
      check_val({tag, "_early0"}, result_ready, m_ready);
      set_in(0, 0, 0, 0);
      @(negedge clk);
      check_val({tag, "_early1"}, result_ready, m_ready);
      result_ack = ack_pub;
      @(negedge clk);
      result_ack = 1'b0;
      if ((m_ready != 0) && !ack_pub) m_ov = (m_ov < 15) ? m_ov + 1 : 15;
      m_ready = 1;
      m_peak  = mx;
      m_bin   = bn;
      m_err   = ((cnt != NB - MB) || ab) ? 1 : 0;
      if (mx >= m_hold) m_hold = mx;
      else begin
         d = m_hold / (1 << DS);
         if ((d == 0) && (m_hold > 0)) d = 1;
         m_hold = m_hold - d;
      end
      check_outputs(tag);
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      m_ready = 0;
      check_val("ack_clear", result_ready, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      set_in(0, 0, 0, 0);
      result_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic fill_random();
      for (int b = 0; b < NB; b++) fdata[b] = 8'($urandom_range(0, 255));
   endtask

   task automatic fill_zero();
      for (int b = 0; b < NB; b++) fdata[b] = 8'h00;
   endtask

   initial begin
      logic [7:0] seq [3];
      seq[0] = 8'h70; seq[1] = 8'h62; seq[2] = 8'h56;

      reset_n = 1'b0;
      result_ack = 1'b0;
      set_in(0, 0, 0, 0);
      #2;
      check_outputs("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Ramp kept below the planted peak at bin 300
      for (int b = 0; b < NB; b++) fdata[b] = 8'(b % 128);
      fdata[300] = 8'hF0;
      run_frame("ramp");
      check_val("ramp_peak_const", peak_mag, 8'hF0);
      check_val("ramp_bin_const", peak_bin, 300);
      check_val("ramp_err_const", frame_err, 0);
      ack_pulse();

      // DC bins excluded, tie keeps the lower index
      fill_zero();
      fdata[0] = 8'hFF; fdata[1] = 8'hFE; fdata[40] = 8'h80; fdata[41] = 8'h80;
      run_frame("dc");
      check_val("dc_bin_const", peak_bin, 40);
      check_val("dc_mag_const", peak_mag, 8'h80);
      ack_pulse();

      // Hold decay down to zero
      do_reset();
      fill_zero();
      fdata[50] = 8'h80;
      run_frame("hold0");
      check_val("hold_start", hold_mag, 8'h80);
      fill_zero();
      ack_pub = 1'b1;
      for (int i = 0; i < 40; i++) begin
         run_frame("decay");
         if (i < 3) check_val("hold_seq", hold_mag, seq[i]);
      end
      check_val("hold_zero", hold_mag, 0);
      ack_pub = 1'b0;
      ack_pulse();

      // Aborted frame, then a frame missing one bin, then a clean frame
      fill_random();
      gaps = 1'b1;
      abort_at = 200;
      run_frame("abort");
      check_val("abort_err_const", frame_err, 1);
      abort_at = -1;
      skip_bin = 100;
      run_frame("skip");
      check_val("skip_err_const", frame_err, 1);
      skip_bin = -1;
      run_frame("clean");
      check_val("clean_err_const", frame_err, 0);
      ack_pulse();

      // Overwrites without ack, then ack coinciding with publish
      do_reset();
      ack_pub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fill_random();
         run_frame("ovw");
      end
      check_val("ovw_cnt_const", overwrite_cnt, 2);
      fill_random();
      ack_pub = 1'b1;
      run_frame("ack_pub");
      check_val("ack_pub_ready", result_ready, 1);
      check_val("ack_pub_cnt", overwrite_cnt, 2);
      @(negedge clk);
      check_val("ack_pub_hold", result_ready, 1);
      ack_pulse();

      // Randomized frames
      for (int i = 0; i < 6; i++) begin
         fill_random();
         gaps     = 1'b1;
         ack_pub  = ($urandom_range(0, 1) == 1);
         skip_bin = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 2) : -1;
         abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NB - 1) : -1;
         run_frame("rand");
         if ($urandom_range(0, 1) == 1) ack_pulse();
      end
      skip_bin = -1;
      abort_at = -1;

      // Reset in the middle of a frame
      fill_random();
      gaps = 1'b0;
      @(negedge clk);
      set_in(1, 0, 0, 0);
      for (int b = 0; b <= 250; b++) send_bin(b);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs("mid_reset");
      @(negedge clk);
      reset_n = 1'b1;
      for (int b = 251; b < NB; b++) send_bin(b);
      repeat (5) begin
         @(negedge clk);
         set_in(0, 0, 0, 0);
      end
      check_outputs("no_publish");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
